fft_peak_ctrl: RTL and testbench

Sequencer that sits downstream of the 16-point streaming FFT and schedules a shared power-compare datapath across the 16 bins of each FFT frame. It captures a frame on fft_valid and scans one bin per cycle. It reports the dominant frequency bin (freq) and a done pulse for every frame, counts frames, and flags overrun. Throughput is one frame per 16 cycles, matching the FFT output cadence.

---
 rtl/fft_peak_ctrl_if.sv | 44 ++++
 rtl/fft_peak_ctrl.sv | 172 +++++++++++++++++
 tb/tb_fft_peak_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_peak_ctrl_if.sv
// Bus between the 16-point streaming FFT and the peak sequencer.
// The master side drives the frame strobe and bins; the slave reports the result.
interface fft_peak_ctrl_if #(
  parameter int CNT_W = 6
);
  logic             fft_valid;
  logic [31:0]      fft_d0;
  logic [31:0]      fft_d1;
  logic [31:0]      fft_d2;
  logic [31:0]      fft_d3;
  logic [31:0]      fft_d4;
  logic [31:0]      fft_d5;
  logic [31:0]      fft_d6;
  logic [31:0]      fft_d7;
  logic [31:0]      fft_d8;
  logic [31:0]      fft_d9;
  logic [31:0]      fft_d10;
  logic [31:0]      fft_d11;
  logic [31:0]      fft_d12;
  logic [31:0]      fft_d13;
  logic [31:0]      fft_d14;
  logic [31:0]      fft_d15;
  logic             done;
  logic [3:0]       freq;
  logic [31:0]      peak_pwr;
  logic             busy;
  logic             overrun;
  logic [CNT_W-1:0] frame_cnt;
  logic             finish;

  modport master (
    output fft_valid,
    output fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
    output fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    input  done, freq, peak_pwr, busy, overrun, frame_cnt, finish
  );

  modport slave (
    input  fft_valid,
    input  fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
    input  fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    output done, freq, peak_pwr, busy, overrun, frame_cnt, finish
  );
endinterface

// File: rtl/fft_peak_ctrl.sv
// Scans each captured 16-bin FFT frame one bin per cycle through a shared
// power-compare datapath and reports the dominant bin and its power.
//
//   state  | meaning
//   IDLE   | waiting for a frame strobe (or parked after finish)
//   SCAN   | comparing buffered bin idx against the running maximum
module fft_peak_ctrl #(
  parameter int NUM_FRAMES = 63,
  parameter int CNT_W      = 6
) (
  input logic           clk,
  input logic           rst,
  fft_peak_ctrl_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] NF_C = CNT_W'(NUM_FRAMES);

  state_t           state_q, state_d;
  logic [31:0]      buf_q [16];
  logic [31:0]      buf_d [16];
  logic [31:0]      din   [16];
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       max_idx_q, max_idx_d;
  logic [31:0]      max_pwr_q, max_pwr_d;
  logic [3:0]       freq_q, freq_d;
  logic [31:0]      peak_q, peak_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             finish_q, finish_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [CNT_W-1:0] cnt_inc;
  logic signed [15:0] re, im;
  logic signed [31:0] re_sq, im_sq;
  logic [31:0]      pwr;
  logic             gt;
  logic [31:0]      win_pwr;
  logic [3:0]       win_idx;
  logic             last;
  logic             capture_idle;
  logic             capture_b2b;

  always_comb begin
    din[0]  = bus.fft_d0;
    din[1]  = bus.fft_d1;
    din[2]  = bus.fft_d2;
    din[3]  = bus.fft_d3;
    din[4]  = bus.fft_d4;
    din[5]  = bus.fft_d5;
    din[6]  = bus.fft_d6;
    din[7]  = bus.fft_d7;
    din[8]  = bus.fft_d8;
    din[9]  = bus.fft_d9;
    din[10] = bus.fft_d10;
    din[11] = bus.fft_d11;
    din[12] = bus.fft_d12;
    din[13] = bus.fft_d13;
    din[14] = bus.fft_d14;
    din[15] = bus.fft_d15;
  end

  // Squares are at most 2^30 each, so the unsigned 32-bit sum cannot wrap.
  always_comb begin
    re      = buf_q[idx_q][31:16];
    im      = buf_q[idx_q][15:0];
    re_sq   = re * re;
    im_sq   = im * im;
    pwr     = $unsigned(re_sq) + $unsigned(im_sq);
    gt      = pwr > max_pwr_q;
    win_pwr = gt ? pwr : max_pwr_q;
    win_idx = gt ? idx_q : max_idx_q;
    last    = (state_q == S_SCAN) && (idx_q == 4'd15);
    cnt_inc = (cnt_q == NF_C) ? cnt_q : cnt_q + CNT_W'(1);
    capture_idle = (state_q == S_IDLE) && bus.fft_valid && !finish_q;
    capture_b2b  = last && bus.fft_valid && (cnt_inc < NF_C);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (capture_idle) state_d = S_SCAN;
      S_SCAN:  if (last && !capture_b2b) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    buf_d     = buf_q;
    idx_d     = idx_q;
    max_idx_d = max_idx_q;
    max_pwr_d = max_pwr_q;
    freq_d    = freq_q;
    peak_d    = peak_q;
    done_d    = 1'b0;
    busy_d    = (state_d == S_SCAN);
    overrun_d = overrun_q;
    finish_d  = finish_q;
    cnt_d     = cnt_q;

    if (state_q == S_SCAN && !last) begin
      max_pwr_d = win_pwr;
      max_idx_d = win_idx;
      idx_d     = idx_q + 4'd1;
      if (bus.fft_valid) overrun_d = 1'b1;
    end

    // The bin-15 compare goes straight to the outputs instead of the running max.
    if (last) begin
      freq_d   = win_idx;
      peak_d   = win_pwr;
      done_d   = 1'b1;
      cnt_d    = cnt_inc;
      finish_d = finish_q | (cnt_inc == NF_C);
      idx_d    = 4'd0;
    end

    if (capture_idle || capture_b2b) begin
      buf_d     = din;
      idx_d     = 4'd0;
      max_pwr_d = '0;
      max_idx_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 16; k++) buf_q[k] <= '0;
      idx_q     <= '0;
      max_idx_q <= '0;
      max_pwr_q <= '0;
      freq_q    <= '0;
      peak_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      finish_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      max_idx_q <= max_idx_d;
      max_pwr_q <= max_pwr_d;
      freq_q    <= freq_d;
      peak_q    <= peak_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      finish_q  <= finish_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.done      = done_q;
  assign bus.freq      = freq_q;
  assign bus.peak_pwr  = peak_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_cnt = cnt_q;
  assign bus.finish    = finish_q;

endmodule

// File: tb/tb_fft_peak_ctrl.sv
// Directed bench for fft_peak_ctrl: cycle-exact checks in the main sequence plus
// a scoreboard that pairs every done pulse with the frame that produced it.
module tb_fft_peak_ctrl;

  localparam int NF = 63;
  localparam int CW = 6;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   done_seen = 0;
  int   done_exp = 0;
  logic [35:0] sb[$];
  logic [31:0] frm [16];

  fft_peak_ctrl_if #(.CNT_W(CW)) bus ();

  fft_peak_ctrl #(.NUM_FRAMES(NF), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frm();
    for (int k = 0; k < 16; k++) frm[k] = '0;
  endtask

  task automatic set_bus();
    bus.fft_d0  = frm[0];
    bus.fft_d1  = frm[1];
    bus.fft_d2  = frm[2];
    bus.fft_d3  = frm[3];
    bus.fft_d4  = frm[4];
    bus.fft_d5  = frm[5];
    bus.fft_d6  = frm[6];
    bus.fft_d7  = frm[7];
    bus.fft_d8  = frm[8];
    bus.fft_d9  = frm[9];
    bus.fft_d10 = frm[10];
    bus.fft_d11 = frm[11];
    bus.fft_d12 = frm[12];
    bus.fft_d13 = frm[13];
    bus.fft_d14 = frm[14];
    bus.fft_d15 = frm[15];
  endtask

  // Reference: exact integer power, first strictly-greater bin wins.
  function automatic logic [35:0] model();
    longint best = 0;
    int     bi = 0;
    for (int k = 0; k < 16; k++) begin
      longint r = longint'($signed(frm[k][31:16]));
      longint i = longint'($signed(frm[k][15:0]));
      longint p = r * r + i * i;
      if (p > best) begin
        best = p;
        bi   = k;
      end
    end
    return {bi[3:0], best[31:0]};
  endfunction

  always @(negedge clk) begin
    if (rst && bus.done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        check("sb_unexpected_done", 1, 0);
      end else begin
        logic [35:0] e;
        e = sb.pop_front();
        check("sb_freq", bus.freq, e[35:32]);
        check("sb_peak", bus.peak_pwr, e[31:0]);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_freq"}, bus.freq, 0);
    check({tag, "_peak"}, bus.peak_pwr, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_ovr"},  bus.overrun, 0);
    check({tag, "_cnt"},  bus.frame_cnt, 0);
    check({tag, "_fin"},  bus.finish, 0);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic run_frame(input string tag, input logic [3:0] ef, input logic [31:0] ep, input int ecnt);
    int bad;
    sb.push_back(model());
    done_exp++;
    set_bus();
    bus.fft_valid = 1'b1;
    tick();
    bus.fft_valid = 1'b0;
    bad = 0;
    repeat (16) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      tick();
    end
    check({tag, "_busy16"}, bad, 0);
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_freq"}, bus.freq, ef);
    check({tag, "_peak"}, bus.peak_pwr, ep);
    check({tag, "_cnt"}, bus.frame_cnt, ecnt);
    check({tag, "_idle"}, bus.busy, 0);
    tick();
    check({tag, "_done_low"}, bus.done, 0);
    check({tag, "_hold_freq"}, bus.freq, ef);
  endtask

  initial begin
    rst = 1'b0;
    bus.fft_valid = 1'b0;
    clear_frm();
    set_bus();
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    clear_frm();
    frm[5] = {16'sd100, 16'sd0};
    run_frame("single", 4'd5, 32'd10000, 1);

    clear_frm();
    frm[3] = {-16'sd3, 16'sd4};
    frm[9] = {-16'sd3, 16'sd4};
    run_frame("tie", 4'd3, 32'd25, 2);

    clear_frm();
    run_frame("zero", 4'd0, 32'd0, 3);

    clear_frm();
    frm[15] = 32'h8000_8000;
    run_frame("extreme", 4'd15, 32'h8000_0000, 4);
    check("extreme_fin", bus.finish, 0);

    // Overrun: second strobe lands on scan edge 5 and must be dropped.
    reset_dut();
    check("ovr_reset_cnt", bus.frame_cnt, 0);
    clear_frm();
    frm[7] = {16'sd0, 16'sd50};
    sb.push_back(model());
    done_exp++;
    set_bus();
    bus.fft_valid = 1'b1;
    tick();
    bus.fft_valid = 1'b0;
    repeat (4) tick();
    check("ovr_pre", bus.overrun, 0);
    clear_frm();
    frm[2] = {16'sd200, 16'sd0};
    set_bus();
    bus.fft_valid = 1'b1;
    tick();
    bus.fft_valid = 1'b0;
    check("ovr_flag", bus.overrun, 1);
    check("ovr_busy", bus.busy, 1);
    repeat (10) tick();
    check("ovr_no_early_done", bus.done, 0);
    tick();
    check("ovr_done", bus.done, 1);
    check("ovr_freq", bus.freq, 7);
    check("ovr_peak", bus.peak_pwr, 2500);
    check("ovr_cnt", bus.frame_cnt, 1);
    repeat (20) tick();
    check("ovr_sticky", bus.overrun, 1);
    check("ovr_cnt_after", bus.frame_cnt, 1);
    check("ovr_idle", bus.busy, 0);

    // Async reset in the middle of a scan.
    reset_dut();
    clear_frm();
    frm[4] = {16'sd30, 16'sd40};
    set_bus();
    bus.fft_valid = 1'b1;
    tick();
    bus.fft_valid = 1'b0;
    repeat (8) tick();
    check("mid_busy", bus.busy, 1);
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_quiet", bus.done, 0);
    run_frame("post_rst", 4'd4, 32'd2500, 1);

    // Back-to-back run to finish.
    reset_dut();
    for (int n = 0; n < NF; n++) begin
      clear_frm();
      for (int k = 0; k < 16; k++) begin
        int vr = int'($urandom_range(0, 100)) - 50;
        int vi = int'($urandom_range(0, 100)) - 50;
        frm[k] = {vr[15:0], vi[15:0]};
      end
      begin
        int pr = 100 + n;
        int pi = -n;
        frm[n % 16] = {pr[15:0], pi[15:0]};
      end
      sb.push_back(model());
      done_exp++;
      set_bus();
      bus.fft_valid = 1'b1;
      tick();
      bus.fft_valid = 1'b0;
      if (n > 0) begin
        check("b2b_done", bus.done, 1);
        check("b2b_freq", bus.freq, (n - 1) % 16);
        check("b2b_busy", bus.busy, 1);
      end
      repeat (15) tick();
    end
    clear_frm();
    frm[1] = {16'sd500, 16'sd0};
    set_bus();
    bus.fft_valid = 1'b1;
    tick();
    bus.fft_valid = 1'b0;
    check("b2b_last_done", bus.done, 1);
    check("b2b_last_freq", bus.freq, (NF - 1) % 16);
    check("b2b_cnt", bus.frame_cnt, NF);
    check("b2b_fin", bus.finish, 1);
    check("b2b_ovr", bus.overrun, 0);
    check("b2b_idle", bus.busy, 0);
    bus.fft_valid = 1'b1;
    tick();
    bus.fft_valid = 1'b0;
    tick();
    check("fin_ignore_busy", bus.busy, 0);
    repeat (20) tick();
    check("fin_cnt_sat", bus.frame_cnt, NF);
    check("fin_level", bus.finish, 1);
    check("fin_hold_freq", bus.freq, (NF - 1) % 16);

    check("sb_empty", sb.size(), 0);
    check("done_total", done_seen, done_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
